// File: rtl/ftdi_fifo_responder.sv
// ftdi_fifo_responder: chip-side model of the FTDI asynchronous 245-FIFO interface
//   i_clock, i_reset        : clock, asynchronous active-high reset
//   i_host_data/_wrreq      : host push into RX (host->FPGA); o_host_full flags RX full
//   i_host_rdreq            : host pop from TX (FPGA->host); o_host_q show-ahead head, o_host_empty
//   o_rxf, o_txe            : registered active-low data-available / space-available flags
//   i_ftdi_rd, i_ftdi_wr    : active-low strobes from the FPGA
//   i_adbus_in              : bus value driven by the FPGA during writes
//   o_adbus_out, o_adbus_oe : RX head byte and drive enable toward the FPGA
//   o_rx_count, o_tx_count  : buffer occupancies; o_proto_err sticky protocol-violation flag
module ftdi_fifo_responder #(
    parameter int DEPTH     = 1024,
    parameter int PRECHARGE = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [7:0]             i_host_data,
    input  logic                   i_host_wrreq,
    output logic                   o_host_full,
    input  logic                   i_host_rdreq,
    output logic [7:0]             o_host_q,
    output logic                   o_host_empty,
    output logic                   o_rxf,
    output logic                   o_txe,
    input  logic                   i_ftdi_rd,
    input  logic                   i_ftdi_wr,
    input  logic [7:0]             i_adbus_in,
    output logic [7:0]             o_adbus_out,
    output logic                   o_adbus_oe,
    output logic [$clog2(DEPTH):0] o_rx_count,
    output logic [$clog2(DEPTH):0] o_tx_count,
    output logic                   o_proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (PRECHARGE > 0) ? $clog2(PRECHARGE + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READING, S_WRITING, S_PRECHARGE} state_t;

    state_t        r_state, w_state_next;
    logic [7:0]    r_rx_mem [DEPTH];
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_rx_count, r_tx_count;
    logic [PW-1:0] r_pc, w_pc_next;
    logic [7:0]    r_hold;
    logic          r_rd_q, r_wr_q, r_rxf, r_txe, r_err;
    logic          w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise, w_err;
    logic          w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_hold_load;
    logic          w_rxf_next, w_txe_next;

    assign w_rd_fall = r_rd_q & ~i_ftdi_rd;
    assign w_rd_rise = ~r_rd_q & i_ftdi_rd;
    assign w_wr_fall = r_wr_q & ~i_ftdi_wr;
    assign w_wr_rise = ~r_wr_q & i_ftdi_wr;

    // rxf/txe are forced high outside IDLE, so edges there are caught by the flag terms
    assign w_err = (~i_ftdi_rd & ~i_ftdi_wr) | (w_rd_fall & r_rxf) | (w_wr_fall & r_txe)
                 | ((r_state == S_READING) & (w_wr_fall | w_wr_rise))
                 | ((r_state == S_WRITING) & (w_rd_fall | w_rd_rise));

    assign w_rx_push = i_host_wrreq & ~o_host_full;
    assign w_tx_pop  = i_host_rdreq & ~o_host_empty;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_rx_pop     = 1'b0;
        w_tx_push    = 1'b0;
        w_hold_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_err && w_rd_fall) w_state_next = S_READING;
                else if (!w_err && w_wr_fall) begin
                    w_state_next = S_WRITING;
                    w_hold_load  = 1'b1;
                end
            end
            S_READING: begin
                if (w_rd_rise) begin
                    w_rx_pop     = 1'b1;
                    w_pc_next    = PW'(PRECHARGE);
                    w_state_next = (PRECHARGE == 0) ? S_IDLE : S_PRECHARGE;
                end
            end
            S_WRITING: begin
                // the bus is released as wr rises, so only low-cycle samples are kept
                w_hold_load = ~i_ftdi_wr;
                if (w_wr_rise) begin
                    w_tx_push    = 1'b1;
                    w_pc_next    = PW'(PRECHARGE);
                    w_state_next = (PRECHARGE == 0) ? S_IDLE : S_PRECHARGE;
                end
            end
            default: begin
                w_pc_next    = r_pc - 1'b1;
                w_state_next = (r_pc <= PW'(1)) ? S_IDLE : S_PRECHARGE;
            end
        endcase
    end

    // flags follow the next state; pops/pushes by the FSM count at once, host traffic one cycle late
    assign w_rxf_next = (w_state_next == S_IDLE) ? (r_rx_count == CW'(w_rx_pop)) : 1'b1;
    assign w_txe_next = (w_state_next == S_IDLE) ? (r_tx_count + CW'(w_tx_push) == CW'(DEPTH)) : 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_hold     <= '0;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_rx_count <= '0;
            r_tx_count <= '0;
            r_rxf      <= 1'b1;
            r_txe      <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_rd_q     <= i_ftdi_rd;
            r_wr_q     <= i_ftdi_wr;
            if (w_hold_load) r_hold <= i_adbus_in;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
            r_rx_count <= r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
            r_tx_count <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
            r_rxf      <= w_rxf_next;
            r_txe      <= w_txe_next;
            r_err      <= r_err | w_err;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= i_host_data;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= r_hold;
    end

    assign o_adbus_out  = (r_rx_count == '0) ? 8'h00 : r_rx_mem[r_rx_rp];
    assign o_host_q     = (r_tx_count == '0) ? 8'h00 : r_tx_mem[r_tx_rp];
    assign o_adbus_oe   = ~i_ftdi_rd & ~i_reset;
    assign o_host_full  = (r_rx_count == CW'(DEPTH));
    assign o_host_empty = (r_tx_count == '0);
    assign o_rxf        = r_rxf;
    assign o_txe        = r_txe;
    assign o_rx_count   = r_rx_count;
    assign o_tx_count   = r_tx_count;
    assign o_proto_err  = r_err;
endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// tb_ftdi_fifo_responder: directed bench with a byte scoreboard for both buffer directions
module tb_ftdi_fifo_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  hdata = '0, adin = '0;
    logic        hwr = 1'b0, hrd = 1'b0, ftrd = 1'b1, ftwr = 1'b1;
    logic        host_full, host_empty, rxf, txe, adbus_oe, proto_err;
    logic [7:0]  host_q, adbus_out;
    logic [10:0] rx_count, tx_count;
    int          nvec = 0, nerr = 0;
    logic [7:0]  rx_exp[$];
    logic [7:0]  tx_exp[$];
    logic        prev_rd = 1'b1;

    ftdi_fifo_responder dut (
        .i_clock(clk), .i_reset(rst),
        .i_host_data(hdata), .i_host_wrreq(hwr), .o_host_full(host_full),
        .i_host_rdreq(hrd), .o_host_q(host_q), .o_host_empty(host_empty),
        .o_rxf(rxf), .o_txe(txe), .i_ftdi_rd(ftrd), .i_ftdi_wr(ftwr),
        .i_adbus_in(adin), .o_adbus_out(adbus_out), .o_adbus_oe(adbus_oe),
        .o_rx_count(rx_count), .o_tx_count(tx_count), .o_proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_rxf", 32'(rxf), 1);
        chk("rst_txe", 32'(txe), 1);
        chk("rst_oe", 32'(adbus_oe), 0);
        chk("rst_adbus_out", 32'(adbus_out), 0);
        chk("rst_host_q", 32'(host_q), 0);
        chk("rst_host_full", 32'(host_full), 0);
        chk("rst_host_empty", 32'(host_empty), 1);
        chk("rst_rx_count", 32'(rx_count), 0);
        chk("rst_tx_count", 32'(tx_count), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
    endtask

    task automatic host_push(input logic [7:0] b, input bit accept);
        hdata = b;
        hwr = 1'b1;
        step(1);
        hwr = 1'b0;
        if (accept) rx_exp.push_back(b);
    endtask

    task automatic fpga_read(input int nlow);
        for (int k = 0; k < 16 && rxf; k++) step(1);
        chk("rxf_ready", 32'(rxf), 0);
        ftrd = 1'b0;
        step(nlow);
        ftrd = 1'b1;
        step(1);
    endtask

    task automatic fpga_write(input logic [7:0] b);
        for (int k = 0; k < 16 && txe; k++) step(1);
        chk("txe_ready", 32'(txe), 0);
        ftwr = 1'b0;
        adin = b;
        step(1);
        ftwr = 1'b1;
        adin = 8'h00;
        step(1);
        tx_exp.push_back(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // scoreboard monitor: FPGA samples in its first rd-low cycle; host samples on each accepted pop
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (prev_rd && !ftrd) begin
                if (rx_exp.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rx_underflow: got %0h, expected no read", adbus_out);
                end else begin
                    e = rx_exp.pop_front();
                    chk("adbus_out", 32'(adbus_out), 32'(e));
                end
            end
            prev_rd = ftrd;
            if (hrd && !host_empty) begin
                if (tx_exp.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL tx_underflow: got %0h, expected no pop", host_q);
                end else begin
                    e = tx_exp.pop_front();
                    chk("host_q", 32'(host_q), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        chk_reset();
        rst = 1'b0;
        step(1);

        // single host byte served to one FPGA read
        host_push(8'hA5, 1'b1);
        chk("t1_rx_count", 32'(rx_count), 1);
        chk("t1_rxf_lag", 32'(rxf), 1);
        step(1);
        chk("t1_rxf_low", 32'(rxf), 0);
        ftrd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_oe", 32'(adbus_oe), 1);
            chk("t1_adbus_out", 32'(adbus_out), 'hA5);
            step(1);
        end
        ftrd = 1'b1;
        step(1);
        chk("t1_rx_count_after", 32'(rx_count), 0);
        chk("t1_oe_off", 32'(adbus_oe), 0);
        chk("t1_adbus_empty", 32'(adbus_out), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rxf_high", 32'(rxf), 1);
            step(1);
        end

        // single FPGA write handed to the host
        chk("t2_txe_ready", 32'(txe), 0);
        ftwr = 1'b0;
        adin = 8'h3C;
        step(2);
        ftwr = 1'b1;
        adin = 8'h00;
        tx_exp.push_back(8'h3C);
        step(1);
        chk("t2_tx_count", 32'(tx_count), 1);
        chk("t2_host_q", 32'(host_q), 'h3C);
        chk("t2_host_empty", 32'(host_empty), 0);
        chk("t2_txe_pc0", 32'(txe), 1);
        step(1);
        chk("t2_txe_pc1", 32'(txe), 1);
        step(1);
        chk("t2_txe_low", 32'(txe), 0);
        hrd = 1'b1;
        step(1);
        hrd = 1'b0;
        chk("t2_host_empty_after", 32'(host_empty), 1);
        chk("t2_host_q_empty", 32'(host_q), 0);

        // fill RX completely across the pointer wrap, overflow, then drain in order
        for (int i = 0; i < 1024; i++) host_push(8'(i), 1'b1);
        chk("t3_host_full", 32'(host_full), 1);
        chk("t3_rx_count_full", 32'(rx_count), 1024);
        host_push(8'h77, 1'b0);
        chk("t3_rx_count_ovf", 32'(rx_count), 1024);
        for (int i = 0; i < 1024; i++) fpga_read(1);
        step(3);
        chk("t3_rx_count_empty", 32'(rx_count), 0);
        chk("t3_host_full_clr", 32'(host_full), 0);
        chk("t3_rxf_empty", 32'(rxf), 1);

        // fill TX completely, then an extra write strobe is a violation
        chk("t4_proto_err_pre", 32'(proto_err), 0);
        for (int i = 0; i < 1024; i++) fpga_write(8'(i * 7 + 3));
        step(3);
        chk("t4_txe_full", 32'(txe), 1);
        chk("t4_tx_count_full", 32'(tx_count), 1024);
        ftwr = 1'b0;
        adin = 8'hEE;
        step(1);
        chk("t4_proto_err", 32'(proto_err), 1);
        ftwr = 1'b1;
        adin = 8'h00;
        step(3);
        chk("t4_tx_count_hold", 32'(tx_count), 1024);
        chk("t4_proto_err_sticky", 32'(proto_err), 1);
        hrd = 1'b1;
        step(1024);
        hrd = 1'b0;
        chk("t4_host_empty", 32'(host_empty), 1);
        chk("t4_tx_count_drained", 32'(tx_count), 0);

        // both strobes low together: flagged, ignored, FSM remains idle
        do_reset();
        chk("t5_proto_err_pre", 32'(proto_err), 0);
        host_push(8'h5A, 1'b1);
        step(1);
        chk("t5_rxf_low", 32'(rxf), 0);
        ftrd = 1'b0;
        ftwr = 1'b0;
        step(1);
        chk("t5_proto_err", 32'(proto_err), 1);
        ftrd = 1'b1;
        ftwr = 1'b1;
        step(2);
        chk("t5_rx_count", 32'(rx_count), 1);
        chk("t5_tx_count", 32'(tx_count), 0);
        chk("t5_rxf_idle", 32'(rxf), 0);
        chk("t5_txe_idle", 32'(txe), 0);

        // reset asserted in the middle of a read
        do_reset();
        rx_exp.delete();
        for (int i = 1; i <= 5; i++) host_push(8'(i * 'h11), 1'b1);
        step(1);
        chk("t6_rx_count", 32'(rx_count), 5);
        ftrd = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        chk_reset();
        rx_exp.delete();
        ftrd = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        host_push(8'hE1, 1'b1);
        fpga_read(2);
        step(3);
        chk("t6_rx_count_after", 32'(rx_count), 0);
        chk("t6_proto_err", 32'(proto_err), 0);

        chk("rx_queue_left", 32'(rx_exp.size()), 0);
        chk("tx_queue_left", 32'(tx_exp.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ftdi_fifo_responder.md
Name: ftdi_fifo_responder

Overview:
- Synthesizable model of the FTDI chip side of the asynchronous 245-FIFO interface.
- Drives the active-low rxf/txe flags, serves bytes on ftdi_rd strobes and captures bytes on ftdi_wr strobes.
- A host-side push/pop port stands in for the USB host, so the FPGA-side FTDI interface can be looped back on-chip and exercised in simulation without the real chip.
- Runs in the same clock domain as the FPGA-side interface.

Parameters:
- DEPTH, 1024, byte capacity of each internal buffer (RX: host->FPGA, TX: FPGA->host); power of two.
- PRECHARGE, 2, cycles rxf/txe are held inactive after a strobe completes.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- host_data  in  8  byte pushed into the RX buffer.
- host_wrreq  in  1  push host_data; ignored when host_full.
- host_full  out  1  RX buffer full.
- host_rdreq  in  1  pop the TX buffer; ignored when host_empty.
- host_q  out  8  TX buffer head byte, show-ahead.
- host_empty  out  1  TX buffer empty.
- rxf  out  1  active-low: byte available to read.
- txe  out  1  active-low: space available to write.
- ftdi_rd  in  1  active-low read strobe from the FPGA.
- ftdi_wr  in  1  active-low write strobe from the FPGA.
- adbus_in  in  8  bus value driven by the FPGA during writes.
- adbus_out  out  8  bus value driven toward the FPGA.
- adbus_oe  out  1  responder drives the bus.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values:
  - rxf=1, txe=1, adbus_oe=0, adbus_out=0, host_q=0.
  - host_full=0, host_empty=1, counts=0, proto_err=0.
  - FSM in IDLE; pointers cleared.
  - Reset mid-transaction discards buffer contents and any held byte.
- Buffers: circular, separate read/write pointers, pointer wrap at DEPTH. Count = stored entries (0..DEPTH). A push and a pop in the same cycle leave the count unchanged.
- Strobe sampling: ftdi_rd and ftdi_wr are registered once (rd_q, wr_q) for edge detection.
  - Falling edge: rd_q=1 and ftdi_rd=0.
  - Rising edge: rd_q=0 and ftdi_rd=1.
  - ftdi_wr uses the same rule.
- adbus_out always presents the RX head byte (0 when the RX buffer is empty).
- adbus_oe = ~ftdi_rd, combinational, so data is valid in the same cycle the strobe goes low. The FPGA samples in its first RD-low cycle.
- FSM states: IDLE, READING, WRITING, PRECHARGE.
  - IDLE:
    - rxf = (rx_count==0).
    - txe = (tx_count==DEPTH).
    - On rd falling edge with rxf low: go to READING.
    - On wr falling edge with txe low: go to WRITING, and load the hold register from adbus_in.
  - READING: rxf=1, txe=1. On rd rising edge: pop the RX head, load the precharge counter with PRECHARGE, go to PRECHARGE.
  - WRITING:
    - rxf=1, txe=1.
    - Every cycle with ftdi_wr=0, adbus_in is loaded into the hold register; the last low-cycle value wins.
    - On wr rising edge: push the hold register into TX, load the precharge counter, go to PRECHARGE.
    - The FPGA releases the bus on the same edge that wr rises, so the value sampled at the rising edge is never used.
  - PRECHARGE: rxf=1, txe=1, counter decrements; at 1, go to IDLE. PRECHARGE=0 means return to IDLE directly.
- Protocol violations: set proto_err (sticky until reset); the offending strobe is ignored; state is unchanged.
  - rd falling edge while rxf=1.
  - wr falling edge while txe=1.
  - Both strobes low in the same cycle.
  - A wr edge in READING, or an rd edge in WRITING.
- Host push and pop operate in any FSM state. A host push while in IDLE updates rxf one cycle later, from the registered count.
- The flags are registered outputs and change only on clock edges, so the FPGA's two-flop synchronizer sees clean levels.

Test Plan:
1. After reset, host pushes 0xA5 -> rx_count=1; rxf=0 one cycle later. FPGA read cycle (rd low 3 cycles) -> adbus_oe=1 and adbus_out=0xA5 during all 3; rx_count=0 after the rd rise; rxf=1 for PRECHARGE=2 cycles, then stays 1 (buffer empty).
2. FPGA writes 0x3C (data set, wr low 2 cycles, wr high with bus released) -> tx_count=1, host_q=0x3C, host_empty=0; txe=1 for 2 cycles, then 0.
3. Push 1024 bytes 0x00..0xFF repeating, then read them all back -> bytes in order, pointer wrap exercised. host_full=1 at 1024; a 1025th push is ignored.
4. Fill TX with 1024 FPGA writes -> txe stays 1. A further wr strobe -> proto_err=1, tx_count stays 1024.
5. ftdi_rd and ftdi_wr pulled low in the same cycle -> proto_err=1, no pop, no push, FSM stays IDLE.
6. Assert reset during READING with rx_count=5 -> all outputs return to reset values immediately; rx_count=0; a subsequent read works normally.
